// File: rtl/bitty_fetch.sv
// Bitty instruction sequencer: fetches from a 1-cycle ROM, resolves branches locally,
// and hands other instructions to the CPU via run/done. Define BITTY_FETCH_RETIRE_CNT_EN for a retired-instruction counter.
module bitty_fetch #(
  parameter int          ADDR_W    = 8,
  parameter int unsigned RESET_PC  = 0,
  parameter logic [15:0] HALT_INST = 16'hFFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_rdata,
  output logic [15:0]       d_inst,
  output logic              run,
  input  logic              done,
  input  logic [2:0]        alu_flags,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted
`ifdef BITTY_FETCH_RETIRE_CNT_EN
  ,
  output logic [15:0]       retired
`endif
);

  localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_DECODE, S_RUN, S_WAIT, S_HALT
  } state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] br_target;
  logic              is_branch;
  logic              br_taken;
  logic [ADDR_W-1:0] br_next;
  logic              start_ok;

  assign pc_inc    = pc + ADDR_W'(1);
  assign is_branch = (d_inst[1:0] == 2'b10);
  assign br_next   = br_taken ? br_target : pc_inc;
  assign start_ok  = start && (state_reg == S_IDLE || state_reg == S_HALT);

  // Target field is d_inst[ADDR_W+3:4]; positions past bit 15 are zero.
  genvar gi;
  generate
    for (gi = 0; gi < ADDR_W; gi++) begin : g_tgt
      if (gi + 4 < 16) begin : g_bit
        assign br_target[gi] = d_inst[gi+4];
      end else begin : g_zero
        assign br_target[gi] = 1'b0;
      end
    end
  endgenerate

  // alu_flags = {lt, gt, eq}
  always_comb begin
    br_taken = 1'b0;
    case (d_inst[3:2])
      2'b00:   br_taken = alu_flags[0];
      2'b01:   br_taken = alu_flags[1];
      2'b10:   br_taken = alu_flags[2];
      default: br_taken = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
      pc        <= RST_PC;
      mem_addr  <= RST_PC;
      d_inst    <= 16'h0000;
      run       <= 1'b0;
    end else begin
      run <= 1'b0;
      case (state_reg)
        S_IDLE, S_HALT: begin
          if (start) begin
            pc        <= RST_PC;
            mem_addr  <= RST_PC;
            state_reg <= S_FETCH;
          end
        end
        S_FETCH: begin
          mem_addr  <= pc;
          state_reg <= S_LOAD;
        end
        S_LOAD: begin
          d_inst    <= mem_rdata;
          state_reg <= S_DECODE;
        end
        S_DECODE: begin
          if (d_inst == HALT_INST) begin
            state_reg <= S_HALT;
          end else if (is_branch) begin
            pc        <= br_next;
            mem_addr  <= br_next;
            state_reg <= S_FETCH;
          end else begin
            run       <= 1'b1;
            state_reg <= S_RUN;
          end
        end
        S_RUN: state_reg <= S_WAIT;
        S_WAIT: begin
          if (done) begin
            pc        <= pc_inc;
            mem_addr  <= pc_inc;
            state_reg <= S_FETCH;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign busy   = (state_reg != S_IDLE) && (state_reg != S_HALT);
  assign halted = (state_reg == S_HALT);

`ifdef BITTY_FETCH_RETIRE_CNT_EN
  logic retire_evt;
  assign retire_evt = ((state_reg == S_WAIT) && done) ||
                      ((state_reg == S_DECODE) && (d_inst != HALT_INST) && is_branch);

  always_ff @(posedge clk) begin
    if (reset || start_ok) begin
      retired <= 16'h0000;
    end else if (retire_evt) begin
      retired <= retired + 16'h0001;
    end
  end
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_bitty_fetch.sv
// Self-checking bench for bitty_fetch: directed scenarios plus randomized programs
// checked against a transaction-level model of the sequencer.
module tb_bitty_fetch;
  localparam int AW = 4;
  localparam logic [15:0] HALT = 16'hFFFF;

  logic          clk = 1'b0;
  logic          reset, start, done;
  logic [AW-1:0] mem_addr, pc;
  logic [15:0]   mem_rdata, d_inst;
  logic          run, busy, halted;
  logic [2:0]    alu_flags;
`ifdef BITTY_FETCH_RETIRE_CNT_EN
  logic [15:0]   retired;
`endif

  always #5 clk = ~clk;

  bitty_fetch #(.ADDR_W(AW), .RESET_PC(0), .HALT_INST(HALT)) dut (
    .clk(clk), .reset(reset), .start(start), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .d_inst(d_inst), .run(run), .done(done),
    .alu_flags(alu_flags), .pc(pc), .busy(busy), .halted(halted)
`ifdef BITTY_FETCH_RETIRE_CNT_EN
    , .retired(retired)
`endif
  );

  logic [15:0] rom [16];
  always @(posedge clk) mem_rdata <= rom[mem_addr];

  int run_cnt = 0;
  always @(posedge clk) if (run === 1'b1) run_cnt <= run_cnt + 1;

  int n_checks = 0;
  int n_pass   = 0;
  int tick_cnt = 0;
  int ret_m    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    tick_cnt++;
  endtask

  function automatic bit taken(input logic [15:0] inst, input logic [2:0] f);
    case (inst[3:2])
      2'b00:   return f[0];
      2'b01:   return f[1];
      2'b10:   return f[2];
      default: return 1'b1;
    endcase
  endfunction

  task automatic chk_retired(input string tag);
`ifdef BITTY_FETCH_RETIRE_CNT_EN
    chk(tag, {16'h0, retired}, ret_m);
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  // Executes the ROM program from PC 0 one instruction at a time, checking every cycle.
  task automatic run_prog(input int max_inst, input int fix_delay, input int fix_flags,
                          output bit halted_o, output int cyc);
    int pc_m, dly, t0;
    logic [15:0] inst;
    logic [2:0] f;
    t0 = tick_cnt;
    start = 1'b1;
    tick;
    start = 1'b0;
    pc_m = 0;
    ret_m = 0;
    halted_o = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_pc", pc, 0);
    for (int n = 0; n < max_inst; n++) begin
      inst = rom[pc_m];
      f = (fix_flags >= 0) ? 3'(fix_flags) : 3'($urandom_range(0, 7));
      alu_flags = 3'($urandom);
      done = 1'($urandom);
      start = 1'($urandom);
      tick;
      done = 1'b0;
      start = 1'b0;
      alu_flags = 3'($urandom);
      chk("load_addr", mem_addr, pc_m);
      tick;
      alu_flags = f;
      chk("decode_inst", d_inst, inst);
      chk("decode_run", run, 0);
      if (inst == HALT) begin
        tick;
        chk("halt_halted", halted, 1);
        chk("halt_busy", busy, 0);
        chk("halt_pc", pc, pc_m);
        halted_o = 1'b1;
        break;
      end else if (inst[1:0] == 2'b10) begin
        tick;
        pc_m = taken(inst, f) ? int'((inst >> 4) & 16'h000F) : (pc_m + 1) % 16;
        ret_m++;
        chk("branch_pc", pc, pc_m);
        chk("branch_addr", mem_addr, pc_m);
        chk("branch_run", run, 0);
        chk("branch_busy", busy, 1);
        chk_retired("branch_retired");
      end else begin
        done = 1'($urandom);
        tick;
        alu_flags = 3'($urandom);
        chk("run_pulse", run, 1);
        chk("run_inst", d_inst, inst);
        done = 1'($urandom);
        tick;
        chk("wait_run", run, 0);
        dly = (fix_delay >= 0) ? fix_delay : $urandom_range(0, 4);
        for (int k = 0; k < dly; k++) begin
          done = 1'b0;
          start = 1'($urandom);
          tick;
          chk("stall_run", run, 0);
          chk("stall_pc", pc, pc_m);
          chk("stall_busy", busy, 1);
          chk("stall_inst", d_inst, inst);
        end
        done = 1'b1;
        start = 1'b0;
        tick;
        done = 1'b0;
        pc_m = (pc_m + 1) % 16;
        ret_m++;
        chk("exec_pc", pc, pc_m);
        chk("exec_addr", mem_addr, pc_m);
        chk_retired("exec_retired");
      end
    end
    cyc = tick_cnt - t0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick;
    reset = 1'b0;
  endtask

  bit h;
  int cyc, rc0, r;
  logic [15:0] w;

  initial begin
    reset = 1'b1; start = 1'b0; done = 1'b0; alu_flags = 3'b000;
    for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
    tick; tick;
    reset = 1'b0;
    chk("rst_pc", pc, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_inst", d_inst, 0);
    chk("rst_run", run, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    tick;
    chk("idle_busy", busy, 0);

    // One executed instruction then HALT.
    rom[0] = 16'h2000; rom[1] = HALT;
    rc0 = run_cnt;
    run_prog(10, 1, 0, h, cyc);
    $display("txn basic: halted=%0d cycles=%0d pc=%0h", h, cyc, pc);
    chk("basic_halted", h, 1);
    chk("basic_cycles", cyc, 10);
    chk("basic_runs", run_cnt - rc0, 1);
    chk("basic_pc", pc, 1);

    // Branch taken (eq), not taken, and cond 11 always.
    rom[0] = 16'h0032; rom[1] = HALT; rom[3] = HALT;
    run_prog(4, 1, 3'b001, h, cyc);
    $display("txn br_taken: pc=%0h", pc);
    chk("br_taken_pc", pc, 3);
    run_prog(4, 1, 3'b000, h, cyc);
    $display("txn br_not_taken: pc=%0h", pc);
    chk("br_not_taken_pc", pc, 1);
    rom[0] = 16'h003E;
    run_prog(4, 1, 3'b000, h, cyc);
    $display("txn br_always: pc=%0h", pc);
    chk("br_always_pc", pc, 3);

    // Long stall in WAIT.
    rom[0] = 16'h2000; rom[1] = HALT;
    rc0 = run_cnt;
    run_prog(4, 20, 0, h, cyc);
    $display("txn stall: runs=%0d pc=%0h", run_cnt - rc0, pc);
    chk("stall_runs", run_cnt - rc0, 1);
    chk("stall_final_pc", pc, 1);

    // PC wrap from 15 to 0.
    rom[0] = 16'h00FE; rom[15] = 16'h1234;
    run_prog(2, 1, 0, h, cyc);
    $display("txn wrap: pc=%0h addr=%0h", pc, mem_addr);
    chk("wrap_pc", pc, 0);
    chk("wrap_addr", mem_addr, 0);
    do_reset;

    // One branch plus one executed instruction.
    rom[0] = 16'h001E; rom[1] = 16'h2000; rom[2] = HALT;
    run_prog(5, 1, 0, h, cyc);
    $display("txn retire: halted=%0d pc=%0h", h, pc);
    chk("retire_pc", pc, 2);
    ret_m = 2;
    chk_retired("retire_total");

    // Reset while waiting for done, with done asserted alongside reset.
    rom[0] = 16'h2000;
    start = 1'b1; tick; start = 1'b0;
    tick; tick; tick; tick;
    chk("pre_reset_busy", busy, 1);
    done = 1'b1; reset = 1'b1;
    tick;
    reset = 1'b0; done = 1'b0;
    ret_m = 0;
    $display("txn reset_in_wait: pc=%0h inst=%0h", pc, d_inst);
    chk("rw_pc", pc, 0);
    chk("rw_inst", d_inst, 0);
    chk("rw_run", run, 0);
    chk("rw_busy", busy, 0);
    chk("rw_halted", halted, 0);
    chk_retired("rw_retired");

    // Randomized programs.
    for (int p = 0; p < 30; p++) begin
      for (int i = 0; i < 16; i++) begin
        r = $urandom_range(0, 7);
        w = 16'($urandom);
        if (r == 0) w = HALT;
        else if (r <= 3) w = (w & 16'hFFFC) | 16'h0002;
        else begin
          if (w[1:0] == 2'b10) w[0] = 1'b1;
          if (w == HALT) w = 16'h0000;
        end
        rom[i] = w;
      end
      run_prog(25, -1, -1, h, cyc);
      $display("txn random %0d: halted=%0d pc=%0h cycles=%0d", p, h, pc, cyc);
      if (!h) do_reset;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/bitty_fetch.md
Name: bitty_fetch

Overview:
- Instruction sequencer for the Bitty CPU control unit; it is the initiator side of the run/done handshake.
- Fetches 16-bit instructions from a synchronous instruction ROM and holds each on `d_inst`.
- Pulses `run`, then waits for `done` before advancing the PC.
- Resolves branch-format instructions (`format = d_inst[1:0] = 2'b10`) locally using the ALU compare flags; branches are never handed to the CPU.

Parameters:
- ADDR_W, 8, instruction ROM address width; the PC is ADDR_W bits.
- RESET_PC, 0, PC value loaded at reset and on every start.
- HALT_INST, 16'hFFFF, encoding that stops the sequencer.

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  level; begins execution from RESET_PC when in IDLE or HALT.
- mem_addr  out  ADDR_W  ROM read address.
- mem_rdata  in  16  ROM read data; valid the cycle after mem_addr is presented (1-cycle latency).
- d_inst  out  16  registered current instruction to the CPU.
- run  out  1  one-cycle pulse asking the CPU to execute d_inst.
- done  in  1  CPU completion strobe.
- alu_flags  in  3  {lt, gt, eq} from the last ALU compare.
- pc  out  ADDR_W  current PC.
- busy  out  1  high in every state except IDLE and HALT.
- halted  out  1  high in HALT.

Behaviour:
- Reset: sequential, synchronous; wins over all other inputs, including mid-instruction.
  - State goes to IDLE.
  - pc=RESET_PC, mem_addr=RESET_PC, d_inst=16'h0000.
  - run=0, busy=0, halted=0.
- Registers: all outputs are registered except busy and halted, which decode the state register.
- States: IDLE, FETCH, LOAD, DECODE, RUN, WAIT, HALT.
- IDLE: start=1 → pc=RESET_PC, go to FETCH. start is ignored in all states except IDLE and HALT.
- FETCH: mem_addr=pc; go to LOAD.
- LOAD: d_inst <= mem_rdata; go to DECODE.
- DECODE, priority order:
  - d_inst==HALT_INST → HALT; pc unchanged.
  - format==2'b10 → branch.
    - cond=d_inst[3:2]: 00 taken if eq; 01 taken if gt; 10 taken if lt; 11 always taken.
    - Flags are sampled in DECODE.
    - Taken: pc <= d_inst[ADDR_W+3:4]; bits beyond d_inst[15] read as 0 when ADDR_W>12.
    - Not taken: pc <= pc+1.
    - Next state FETCH; run is not asserted.
  - Otherwise → RUN.
- RUN: run=1 for exactly one cycle; go to WAIT.
- WAIT: run=0.
  - done=1 → pc <= pc+1, go to FETCH.
  - done=0 → stay in WAIT. There is no timeout.
- done is ignored outside WAIT, including a done arriving in the same cycle as run.
- d_inst stability: d_inst changes only at the end of LOAD, so it is stable for the whole CPU S0/S1/S2 sequence.
- Latency with the standard CPU (done two cycles after run is sampled):
  - Executed instruction: FETCH, LOAD, DECODE, RUN, WAIT, WAIT = 6 cycles.
  - Branch: 3 cycles.
- PC arithmetic: modulo 2^ADDR_W; pc+1 from all-ones wraps to 0.
- HALT: halted=1, busy=0.
  - start=1 → pc=RESET_PC, go to FETCH.
  - The ROM is not read while halted.

Optional Feature:
- Macro: BITTY_FETCH_RETIRE_CNT_EN.
- Defined:
  - Extra output retired (out, 16) counts instructions completed in WAIT plus branches resolved in DECODE.
  - HALT does not count.
  - Cleared by reset and by start; wraps 16'hFFFF → 0.
- Undefined: no retired port and no counter logic; all other behaviour is identical.

Test Plan:
- Reset then start=1 with ROM[0]=16'h2000, ROM[1]=HALT_INST, done returned 2 cycles after run:
  - exactly one run pulse, with d_inst=16'h2000;
  - halted=1 with pc=1 on the 10th cycle after start.
- Branch taken: ROM[0]=16'h0032 (cond 00, target 3), alu_flags=3'b001 → pc=3 after DECODE, no run pulse, next mem_addr=3.
- Branch not taken: same ROM word with alu_flags=3'b000 → pc=1; cond 11 with flags 000 → pc=target.
- Stalled done: done held low 20 cycles in WAIT →
  - run high exactly once;
  - d_inst and pc unchanged;
  - busy=1 throughout;
  - advance on the first cycle done=1.
- Wraparound with ADDR_W=4, pc=15, non-branch instruction completes → pc=0, mem_addr=0.
- Reset asserted in WAIT; spurious done pulsed while in FETCH:
  - reset → IDLE, run=0, d_inst=0, pc=RESET_PC;
  - the spurious done has no effect.
  - With BITTY_FETCH_RETIRE_CNT_EN: retired=0 after reset and 2 after one run plus one branch.
